emern_rasterizer: RTL and testbench
===================================

// Module: emern_rasterizer
// PURPOSE
//  Per-pixel triangle rasterizer downstream of the SPI frontend. Consumes the packed polygon
//  registers (2 triangles, bg colour, depths, enables) and a pixel stream from the VGA timing
//  stage in polygon space (x 0..127, y 0..63). Emits one 6-bit colour per pixel, fixed latency.
//  Edge coefficients are precomputed once per frame by a setup FSM into an active set that
//  swaps atomically, so SPI writes mid-frame never tear the image.
// PARAMETERS
//  XW  7  pixel/vertex x width
//  YW  6  pixel/vertex y width
//  CW  6  colour width (RRGGBB)
//  DW  3  depth width (0 = nearest)
// PORTS
//  clk            in   1      system clock
//  rst            in   1      synchronous reset, active high
//  frame_start    in   1      1-cycle pulse at vblank start; triggers setup
//  bg_color_in    in   6      background colour
//  poly_color_in  in   12     {B,A} colours
//  v0_x_in/v1_x_in/v2_x_in  in  14  {B,A} vertex x
//  v0_y_in/v1_y_in/v2_y_in  in  12  {B,A} vertex y
//  poly_depth_in  in   6      {B,A} depth
//  poly_enable_in in   2      {B,A} enable
//  pix_valid      in   1      pixel coordinate valid
//  pix_x          in   7      pixel x
//  pix_y          in   6      pixel y
//  color_out      out  6      resolved pixel colour
//  color_valid    out  1      color_out valid (pix_valid delayed 3)
//  setup_busy     out  1      setup FSM not IDLE
// BEHAVIOUR
//  Reset: color_out=0, color_valid=0, setup_busy=0, FSM=IDLE, active set zeroed (enables 0).
//  Setup FSM: IDLE -frame_start-> CAPTURE (snapshot all *_in) -> EDGE (6 cycles, idx 0..5:
//   A edges 01,12,20 then B) -> COMMIT (area test, copy shadow->active) -> IDLE. Busy 8 cycles.
//   frame_start while busy is ignored. rst in any state -> IDLE, shadow/active cleared.
//  Edge a->b: A=ya-yb (s7), B=xb-xa (s8), C=xa*yb-xb*ya (s15); E(x,y)=A*x+B*y+C, s17 signed,
//   sign-extend all terms, no truncation. 2*area = C0+C1+C2 (s17); area==0 -> poly disabled.
//  Pixel pipe, 3 stages, registered every cycle regardless of pix_valid:
//   S1 register pix_x/pix_y/pix_valid; S2 six E values registered; S3 coverage + resolve.
//  Coverage: enabled, area!=0, and all three E>=0 or all three E<=0 (either winding; edges inclusive).
//  Resolve: both covered -> smaller depth wins, tie -> A; one covered -> its colour; none -> bg.
//  color_out = 0 when color_valid=0. Active set changes only at COMMIT; a pixel in flight
//   during COMMIT uses the set sampled at its S2 cycle.
//  Inputs changing without frame_start have no effect on output.
// CONFIGURATION
//  EMERN_RASTER_WIREFRAME_EN defined: covered pixel with any of its three E==0 outputs
//   ~colour of the winning polygon (edge highlight). Undefined: plain fill only.
// STRUCTURE
//  Shared package/header: XW/YW/CW/DW, edge widths (s7/s8/s15/s17), FSM state encodings,
//   edge index -> vertex-pair table.
//  Sub-module emern_edge_eval (A,B,C,x,y -> s17 E), instantiated 6x in S2. Setup uses one
//   shared multiplier pair for C, indexed by the EDGE counter.
// TESTING
//  Reset: hold rst 2 cycles -> color_out=0, color_valid=0, setup_busy=0; any pixel -> bg=0.
//  A: v(10,10),(50,10),(10,40), col 0x30, en; bg 0x03; frame_start -> busy 8 cycles;
//   pix(20,20) -> 0x30 three cycles later; pix(60,50) -> 0x03.
//  Overlap: B same verts col 0x0C depth 1, A depth 5 -> 0x0C; both depth 2 -> 0x30.
//  Degenerate: A v0=v1=v2=(5,5) -> pix(5,5) -> bg; colinear (0,0),(10,10),(20,20) -> bg.
//  Winding: A verts reversed (10,40),(50,10),(10,10) -> pix(20,20) still 0x30; vertex pix(10,10) covered.
//  Tear-free: change A colour to 0x3F mid-frame -> still 0x30; frame_start at busy cycle 3 ignored;
//   after next frame_start+8 -> 0x3F. rst during EDGE -> busy 0 next cycle, output bg.

Source files
------------

// File: rtl/emern_rasterizer_pkg.sv
// Shared widths, setup FSM encoding, edge coefficient record and edge-index -> vertex-pair table
// for the emern_rasterizer block.
package emern_rasterizer_pkg;

  localparam int XW    = 7;   // pixel/vertex x
  localparam int YW    = 6;   // pixel/vertex y
  localparam int CW    = 6;   // colour RRGGBB
  localparam int DW    = 3;   // depth, 0 = nearest
  localparam int AW    = 7;   // A = ya - yb
  localparam int BW    = 8;   // B = xb - xa
  localparam int CCW   = 15;  // C = xa*yb - xb*ya
  localparam int EW    = 17;  // E(x,y) and 2*area
  localparam int NPOLY = 2;
  localparam int NEDGE = 3 * NPOLY;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EDGE    = 2'd2,
    ST_COMMIT  = 2'd3
  } setup_state_t;

  typedef struct packed {
    logic signed [AW-1:0]  a;
    logic signed [BW-1:0]  b;
    logic signed [CCW-1:0] c;
  } edge_coef_t;

  typedef struct packed {
    logic       poly;
    logic [1:0] va;
    logic [1:0] vb;
  } edge_sel_t;

  // Edges 0..2 belong to triangle A (v0->v1, v1->v2, v2->v0), 3..5 to triangle B.
  function automatic edge_sel_t edge_sel(input logic [2:0] idx);
    edge_sel_t s;
    case (idx)
      3'd0:    s = '{poly: 1'b0, va: 2'd0, vb: 2'd1};
      3'd1:    s = '{poly: 1'b0, va: 2'd1, vb: 2'd2};
      3'd2:    s = '{poly: 1'b0, va: 2'd2, vb: 2'd0};
      3'd3:    s = '{poly: 1'b1, va: 2'd0, vb: 2'd1};
      3'd4:    s = '{poly: 1'b1, va: 2'd1, vb: 2'd2};
      3'd5:    s = '{poly: 1'b1, va: 2'd2, vb: 2'd0};
      default: s = '{poly: 1'b0, va: 2'd0, vb: 2'd1};
    endcase
    return s;
  endfunction

  function automatic logic signed [EW-1:0] sext_c(input logic signed [CCW-1:0] c);
    return {{(EW-CCW){c[CCW-1]}}, c};
  endfunction

endpackage

// File: rtl/emern_rasterizer_if.sv
// Pixel stream interface: coordinates in from the VGA timing stage, resolved colour back out.
interface emern_rasterizer_if;
  import emern_rasterizer_pkg::*;

  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] color_out;
  logic          color_valid;

  modport master (output pix_valid, pix_x, pix_y, input  color_out, color_valid);
  modport slave  (input  pix_valid, pix_x, pix_y, output color_out, color_valid);

endinterface

// File: rtl/emern_edge_eval.sv
// Edge function E(x,y) = A*x + B*y + C, evaluated at full 17-bit signed precision.
module emern_edge_eval
  import emern_rasterizer_pkg::*;
(
  input  logic signed [AW-1:0]  a,
  input  logic signed [BW-1:0]  b,
  input  logic signed [CCW-1:0] c,
  input  logic        [XW-1:0]  x,
  input  logic        [YW-1:0]  y,
  output logic signed [EW-1:0]  e
);

  logic signed [EW-1:0] a_s, b_s, c_s, x_s, y_s;

  // Every term is widened to EW first so the products and sum never wrap.
  always_comb begin
    a_s = {{(EW-AW){a[AW-1]}}, a};
    b_s = {{(EW-BW){b[BW-1]}}, b};
    c_s = {{(EW-CCW){c[CCW-1]}}, c};
    x_s = {{(EW-XW){1'b0}}, x};
    y_s = {{(EW-YW){1'b0}}, y};
    e   = a_s * x_s + b_s * y_s + c_s;
  end

endmodule

// File: rtl/emern_rasterizer.sv
// Two-triangle per-pixel rasterizer: a per-frame setup FSM builds edge coefficients into a shadow
// set that swaps into the active set atomically, feeding a fixed 3-stage pixel pipe.
// Build option: EMERN_RASTER_WIREFRAME_EN inverts the winning colour on covered edge pixels.
module emern_rasterizer
  import emern_rasterizer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [CW-1:0]       bg_color_in,
  input  logic [NPOLY*CW-1:0] poly_color_in,
  input  logic [NPOLY*XW-1:0] v0_x_in,
  input  logic [NPOLY*XW-1:0] v1_x_in,
  input  logic [NPOLY*XW-1:0] v2_x_in,
  input  logic [NPOLY*YW-1:0] v0_y_in,
  input  logic [NPOLY*YW-1:0] v1_y_in,
  input  logic [NPOLY*YW-1:0] v2_y_in,
  input  logic [NPOLY*DW-1:0] poly_depth_in,
  input  logic [NPOLY-1:0]    poly_enable_in,
  emern_rasterizer_if.slave   pix,
  output logic                setup_busy
);

  setup_state_t state_q, state_d;
  logic [2:0]   edge_idx_q;

  // Snapshot of the polygon registers taken in CAPTURE, plus the shadow edge set.
  logic [XW-1:0] snap_vx  [NPOLY][3];
  logic [YW-1:0] snap_vy  [NPOLY][3];
  logic [CW-1:0] snap_col [NPOLY];
  logic [DW-1:0] snap_dep [NPOLY];
  logic [NPOLY-1:0] snap_en;
  logic [CW-1:0] snap_bg;
  edge_coef_t    sh_edge  [NEDGE];

  edge_coef_t    act_edge [NEDGE];
  logic [CW-1:0] act_col  [NPOLY];
  logic [DW-1:0] act_dep  [NPOLY];
  logic [NPOLY-1:0] act_en;
  logic [CW-1:0] act_bg;

  edge_sel_t        sel;
  logic [XW-1:0]    xa, xb;
  logic [YW-1:0]    ya, yb;
  logic [XW+YW-1:0] prod_ab, prod_ba;
  edge_coef_t       edge_new;
  logic [NPOLY-1:0] area_nz;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and
    // no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frame_start) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_EDGE;
      ST_EDGE:    if (edge_idx_q == 3'(NEDGE - 1)) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    setup_busy = (state_q != ST_IDLE);
  end

  // One shared multiplier pair, steered to the current edge's vertex pair.
  always_comb begin
    sel        = edge_sel(edge_idx_q);
    xa         = snap_vx[sel.poly][sel.va];
    ya         = snap_vy[sel.poly][sel.va];
    xb         = snap_vx[sel.poly][sel.vb];
    yb         = snap_vy[sel.poly][sel.vb];
    prod_ab    = {{YW{1'b0}}, xa} * {{XW{1'b0}}, yb};
    prod_ba    = {{YW{1'b0}}, xb} * {{XW{1'b0}}, ya};
    edge_new.a = {1'b0, ya} - {1'b0, yb};
    edge_new.b = {1'b0, xb} - {1'b0, xa};
    edge_new.c = {2'b00, prod_ab} - {2'b00, prod_ba};
  end

  // A zero 2*area (point or colinear triangle) disables the polygon at commit.
  always_comb begin
    area_nz = '0;
    for (int p = 0; p < NPOLY; p++) begin
      area_nz[p] = (sext_c(sh_edge[3*p].c) + sext_c(sh_edge[3*p+1].c)
                    + sext_c(sh_edge[3*p+2].c)) != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state registers use <= so all flops update from pre-edge values; = would make
      // the result depend on block evaluation order.
      state_q    <= ST_IDLE;
      edge_idx_q <= '0;
      // NOTE: these arrays are plain flops rather than inferred RAM, so they can be cleared
      // on reset, which keeps the active set from showing stale triangles.
      snap_vx    <= '{default: '0};
      snap_vy    <= '{default: '0};
      snap_col   <= '{default: '0};
      snap_dep   <= '{default: '0};
      snap_en    <= '0;
      snap_bg    <= '0;
      sh_edge    <= '{default: '0};
      act_edge   <= '{default: '0};
      act_col    <= '{default: '0};
      act_dep    <= '{default: '0};
      act_en     <= '0;
      act_bg     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_CAPTURE: begin
          for (int p = 0; p < NPOLY; p++) begin
            snap_vx[p][0] <= v0_x_in[p*XW +: XW];
            snap_vx[p][1] <= v1_x_in[p*XW +: XW];
            snap_vx[p][2] <= v2_x_in[p*XW +: XW];
            snap_vy[p][0] <= v0_y_in[p*YW +: YW];
            snap_vy[p][1] <= v1_y_in[p*YW +: YW];
            snap_vy[p][2] <= v2_y_in[p*YW +: YW];
            snap_col[p]   <= poly_color_in[p*CW +: CW];
            snap_dep[p]   <= poly_depth_in[p*DW +: DW];
          end
          snap_en    <= poly_enable_in;
          snap_bg    <= bg_color_in;
          edge_idx_q <= '0;
        end
        ST_EDGE: begin
          sh_edge[edge_idx_q] <= edge_new;
          edge_idx_q          <= edge_idx_q + 3'd1;
        end
        ST_COMMIT: begin
          act_edge <= sh_edge;
          act_col  <= snap_col;
          act_dep  <= snap_dep;
          act_bg   <= snap_bg;
          act_en   <= snap_en & area_nz;
        end
        default: ;
      endcase
    end
  end

  // ---------------- pixel pipe ----------------
  logic                 s1_valid;
  logic [XW-1:0]        s1_x;
  logic [YW-1:0]        s1_y;
  logic signed [EW-1:0] e_w  [NEDGE];
  logic                 s2_valid;
  logic signed [EW-1:0] s2_e [NEDGE];
  logic [CW-1:0]        s2_col [NPOLY];
  logic [DW-1:0]        s2_dep [NPOLY];
  logic [NPOLY-1:0]     s2_en;
  logic [CW-1:0]        s2_bg;

  for (genvar g = 0; g < NEDGE; g++) begin : g_edge
    emern_edge_eval u_edge_eval (
      .a (act_edge[g].a),
      .b (act_edge[g].b),
      .c (act_edge[g].c),
      .x (s1_x),
      .y (s1_y),
      .e (e_w[g])
    );
  end

  logic [NEDGE-1:0] e_ge, e_le, e_zero;
  logic [NPOLY-1:0] cov;
`ifdef EMERN_RASTER_WIREFRAME_EN
  logic [NPOLY-1:0] on_edge;
`endif
  logic             win;
  logic [CW-1:0]    resolved;

  // Inclusive coverage for either winding; B wins only when strictly nearer than a covered A.
  always_comb begin
    cov = '0;
`ifdef EMERN_RASTER_WIREFRAME_EN
    on_edge = '0;
`endif
    for (int i = 0; i < NEDGE; i++) begin
      e_zero[i] = (s2_e[i] == '0);
      e_ge[i]   = !s2_e[i][EW-1];
      e_le[i]   = s2_e[i][EW-1] || e_zero[i];
    end
    for (int p = 0; p < NPOLY; p++) begin
      cov[p] = s2_en[p] && ((&e_ge[3*p +: 3]) || (&e_le[3*p +: 3]));
`ifdef EMERN_RASTER_WIREFRAME_EN
      on_edge[p] = |e_zero[3*p +: 3];
`endif
    end
    win = cov[1] && (!cov[0] || (s2_dep[1] < s2_dep[0]));
    if (cov == '0) begin
      resolved = s2_bg;
    end else begin
`ifdef EMERN_RASTER_WIREFRAME_EN
      resolved = on_edge[win] ? ~s2_col[win] : s2_col[win];
`else
      resolved = s2_col[win];
`endif
    end
  end

  // Polygon attributes travel with the pixel from S2 so a commit mid-flight cannot split a pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_x            <= '0;
      s1_y            <= '0;
      s2_valid        <= 1'b0;
      s2_e            <= '{default: '0};
      s2_col          <= '{default: '0};
      s2_dep          <= '{default: '0};
      s2_en           <= '0;
      s2_bg           <= '0;
      pix.color_valid <= 1'b0;
      pix.color_out   <= '0;
    end else begin
      s1_valid        <= pix.pix_valid;
      s1_x            <= pix.pix_x;
      s1_y            <= pix.pix_y;
      s2_valid        <= s1_valid;
      s2_e            <= e_w;
      s2_col          <= act_col;
      s2_dep          <= act_dep;
      s2_en           <= act_en;
      s2_bg           <= act_bg;
      pix.color_valid <= s2_valid;
      pix.color_out   <= s2_valid ? resolved : '0;
    end
  end

endmodule

// File: tb/tb_emern_rasterizer.sv
// Self-checking bench for emern_rasterizer: integer-arithmetic triangle model with a per-cycle
// compare of color_out/color_valid/setup_busy, plus directed hand-computed expectations.
module tb_emern_rasterizer;
  import emern_rasterizer_pkg::*;

`ifdef EMERN_RASTER_WIREFRAME_EN
  localparam bit WIREFRAME = 1'b1;
`else
  localparam bit WIREFRAME = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  bg;
    logic [11:0] col;
    logic [13:0] x0, x1, x2;
    logic [11:0] y0, y1, y2;
    logic [5:0]  dep;
    logic [1:0]  en;
  } pset_t;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst;
  logic  frame_start;
  logic  setup_busy;
  pset_t cfg;

  emern_rasterizer_if bus ();

  emern_rasterizer dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .bg_color_in    (cfg.bg),
    .poly_color_in  (cfg.col),
    .v0_x_in        (cfg.x0),
    .v1_x_in        (cfg.x1),
    .v2_x_in        (cfg.x2),
    .v0_y_in        (cfg.y0),
    .v1_y_in        (cfg.y1),
    .v2_y_in        (cfg.y2),
    .poly_depth_in  (cfg.dep),
    .poly_enable_in (cfg.en),
    .pix            (bus),
    .setup_busy     (setup_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model state: the polygon set in force, the one being set up, and the expected output delay line.
  pset_t      act_m, pend_m;
  int         busy_m;
  logic       s1_v, e2_v, e3_v;
  int         s1_x, s1_y;
  logic [5:0] e2_c, e3_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] wf(input logic [5:0] c, input bit on_edge);
    return (WIREFRAME && on_edge) ? ~c : c;
  endfunction

  // Expected colour of pixel (px,py) straight from the edge-function definition.
  function automatic logic [5:0] model_pixel(input int px, input int py, input pset_t s);
    int vx[3], vy[3], e[3], area, w, a, b;
    bit cov[2], hit[2], pos, neg;
    logic [5:0] col[2];
    int dep[2];
    for (int p = 0; p < 2; p++) begin
      vx[0] = int'(s.x0[p*7 +: 7]); vx[1] = int'(s.x1[p*7 +: 7]); vx[2] = int'(s.x2[p*7 +: 7]);
      vy[0] = int'(s.y0[p*6 +: 6]); vy[1] = int'(s.y1[p*6 +: 6]); vy[2] = int'(s.y2[p*6 +: 6]);
      area = 0; pos = 1'b1; neg = 1'b1; hit[p] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        a = i; b = (i + 1) % 3;
        e[i] = (vy[a] - vy[b]) * px + (vx[b] - vx[a]) * py + vx[a] * vy[b] - vx[b] * vy[a];
        area += vx[a] * vy[b] - vx[b] * vy[a];
        if (e[i] < 0) pos = 1'b0;
        if (e[i] > 0) neg = 1'b0;
        if (e[i] == 0) hit[p] = 1'b1;
      end
      cov[p] = s.en[p] && (area != 0) && (pos || neg);
      col[p] = s.col[p*6 +: 6];
      dep[p] = int'(s.dep[p*3 +: 3]);
    end
    if (cov[0] && cov[1]) w = (dep[1] < dep[0]) ? 1 : 0;
    else if (cov[0])      w = 0;
    else if (cov[1])      w = 1;
    else                  return s.bg;
    return wf(col[w], hit[w]);
  endfunction

  // One clock: advance the model at the edge, compare every DUT output at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      busy_m = 0; act_m = '0; pend_m = '0;
      s1_v = 1'b0; s1_x = 0; s1_y = 0;
      e2_v = 1'b0; e2_c = '0; e3_v = 1'b0; e3_c = '0;
    end else begin
      e3_v = e2_v; e3_c = e2_c;
      e2_v = s1_v; e2_c = s1_v ? model_pixel(s1_x, s1_y, act_m) : 6'h00;
      s1_v = bus.pix_valid; s1_x = int'(bus.pix_x); s1_y = int'(bus.pix_y);
      if (busy_m != 0) begin
        if (busy_m == 8) pend_m = cfg;
        if (busy_m == 1) act_m = pend_m;
        busy_m--;
      end else if (frame_start) begin
        busy_m = 8;
      end
    end
    @(negedge clk);
    if (chk_en) begin
      check("cyc_color_valid", 32'(bus.color_valid), 32'(e3_v));
      check("cyc_color_out",   32'(bus.color_out),   32'(e3_c));
      check("cyc_setup_busy",  32'(setup_busy),      32'(busy_m != 0));
    end
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [5:0] exp);
    bus.pix_valid = 1'b1; bus.pix_x = 7'(x); bus.pix_y = 6'(y);
    step();
    bus.pix_valid = 1'b0;
    step();
    step();
    check({name, "_valid"}, 32'(bus.color_valid), 32'd1);
    check(name, 32'(bus.color_out), 32'(exp));
  endtask

  // Pulse frame_start, optionally re-pulse it while busy, and require exactly 8 busy cycles.
  task automatic do_frame(input string name, input int extra_at);
    int n;
    n = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    while (setup_busy === 1'b1 && n < 20) begin
      n++;
      frame_start = (n == extra_at);
      step();
    end
    frame_start = 1'b0;
    check(name, 32'(n), 32'd8);
  endtask

  task automatic set_poly(input int p, input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input logic [5:0] col,
                          input logic [2:0] dep, input bit en);
    cfg.x0[p*7 +: 7] = 7'(x0); cfg.y0[p*6 +: 6] = 6'(y0);
    cfg.x1[p*7 +: 7] = 7'(x1); cfg.y1[p*6 +: 6] = 6'(y1);
    cfg.x2[p*7 +: 7] = 7'(x2); cfg.y2[p*6 +: 6] = 6'(y2);
    cfg.col[p*6 +: 6] = col;
    cfg.dep[p*3 +: 3] = dep;
    cfg.en[p]         = en;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sx[8];
    int sy[8];
    rst = 1'b1; frame_start = 1'b0; cfg = '0;
    bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0;

    // Pin the model with hand-derived values (triangle A, its reverse, a point triangle).
    cfg.bg = 6'h03;
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd0, 1'b1);
    check("pin_a_inside",  32'(model_pixel(20, 20, cfg)), 32'h30);
    check("pin_a_outside", 32'(model_pixel(60, 50, cfg)), 32'h03);
    set_poly(0, 10, 40, 50, 10, 10, 10, 6'h30, 3'd0, 1'b1);
    check("pin_rev_vertex", 32'(model_pixel(10, 10, cfg)), 32'(wf(6'h30, 1'b1)));
    set_poly(0, 5, 5, 5, 5, 5, 5, 6'h30, 3'd0, 1'b1);
    check("pin_point_tri", 32'(model_pixel(5, 5, cfg)), 32'h03);
    cfg = '0;

    // Reset held for two cycles.
    step();
    chk_en = 1'b1;
    step();
    check("rst_color_out",   32'(bus.color_out),   32'h0);
    check("rst_color_valid", 32'(bus.color_valid), 32'h0);
    check("rst_setup_busy",  32'(setup_busy),      32'h0);
    rst = 1'b0;
    probe("rst_pixel_bg", 20, 20, 6'h00);

    // Triangle A alone.
    cfg.bg = 6'h03;
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd0, 1'b1);
    set_poly(1, 0, 0, 0, 0, 0, 0, 6'h00, 3'd0, 1'b0);
    do_frame("busy_len_a", 0);
    probe("a_inside", 20, 20, 6'h30);
    probe("a_outside", 60, 50, 6'h03);

    // Back-to-back pixel stream, including edges, vertices and the coordinate corners.
    sx = '{20, 60, 10, 30, 11, 0, 127, 29};
    sy = '{20, 50, 10, 10, 39, 0, 63, 25};
    for (int i = 0; i < 8; i++) begin
      bus.pix_valid = 1'b1; bus.pix_x = 7'(sx[i]); bus.pix_y = 6'(sy[i]);
      step();
    end
    bus.pix_valid = 1'b0;
    repeat (3) step();

    // Overlap: nearer B wins, then a depth tie goes to A.
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd5, 1'b1);
    set_poly(1, 10, 10, 50, 10, 10, 40, 6'h0C, 3'd1, 1'b1);
    do_frame("busy_len_ovl", 0);
    probe("overlap_b_near", 20, 20, 6'h0C);
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd2, 1'b1);
    set_poly(1, 10, 10, 50, 10, 10, 40, 6'h0C, 3'd2, 1'b1);
    do_frame("busy_len_tie", 0);
    probe("overlap_tie_a", 20, 20, 6'h30);

    // Degenerate triangles resolve to background.
    set_poly(0, 5, 5, 5, 5, 5, 5, 6'h30, 3'd0, 1'b1);
    set_poly(1, 0, 0, 0, 0, 0, 0, 6'h00, 3'd0, 1'b0);
    do_frame("busy_len_point", 0);
    probe("degen_point", 5, 5, 6'h03);
    set_poly(0, 0, 0, 10, 10, 20, 20, 6'h30, 3'd0, 1'b1);
    do_frame("busy_len_colin", 0);
    probe("degen_colinear", 10, 10, 6'h03);

    // Reversed winding still fills; a vertex pixel counts as covered.
    set_poly(0, 10, 40, 50, 10, 10, 10, 6'h30, 3'd0, 1'b1);
    do_frame("busy_len_rev", 0);
    probe("rev_inside", 20, 20, 6'h30);
    probe("rev_vertex", 10, 10, wf(6'h30, 1'b1));

    // Tear-free: a colour change without frame_start is invisible until the next setup commits.
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd0, 1'b1);
    do_frame("busy_len_tf0", 0);
    cfg.col[5:0] = 6'h3F;
    probe("tear_old_colour", 20, 20, 6'h30);
    bus.pix_valid = 1'b1; bus.pix_x = 7'd20; bus.pix_y = 6'd20;
    do_frame("busy_len_refire", 3);
    bus.pix_valid = 1'b0;
    repeat (3) step();
    check("refire_ignored_busy", 32'(setup_busy), 32'h0);
    probe("tear_new_colour", 20, 20, 6'h3F);

    // Reset in the middle of EDGE.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_edge_busy", 32'(setup_busy), 32'h0);
    rst = 1'b0;
    probe("rst_edge_bg", 20, 20, 6'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
